// File: rtl/control_pipe.sv
// Pipelined MIPS control unit: combinational ID decode feeding registered EX/MEM/WB
// control stages, with load-use interlock, multi-cycle mult/div sequencing and flush.
module control_pipe #(
    parameter int MULDIV_LAT = 4,
    parameter int HAS_MULDIV = 1,
    parameter int REGW       = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [5:0]      op,
    input  logic [5:0]      fn,
    input  logic [REGW-1:0] rs,
    input  logic [REGW-1:0] rt,
    input  logic [REGW-1:0] rd,
    input  logic            flush,
    output logic            stall,
    output logic            illegal,
    output logic [2:0]      ex_aluop,
    output logic [1:0]      ex_shiftop,
    output logic            ex_selimregb,
    output logic            ex_selalushift,
    output logic            ex_unsig,
    output logic [2:0]      ex_compop,
    output logic [1:0]      ex_selbrjumpz,
    output logic [1:0]      ex_selpctype,
    output logic [1:0]      ex_selregdest,
    output logic            ex_muldiv,
    output logic            mem_readmem,
    output logic            mem_writemem,
    output logic            wb_writereg,
    output logic            wb_writeov,
    output logic [2:0]      wb_selwsource,
    output logic [REGW-1:0] wb_dest
);

    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_XOR = 3'd5;
    localparam logic [2:0] ALU_NOR = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;
    localparam logic [3:0] LAT_M1  = 4'(MULDIV_LAT - 1);

    typedef struct packed {
        logic            writereg;
        logic            writeov;
        logic [2:0]      selwsource;
        logic [REGW-1:0] dest;
    } wb_t;

    typedef struct packed {
        logic readmem;
        logic writemem;
        wb_t  w;
    } mem_t;

    typedef struct packed {
        logic [2:0] aluop;
        logic [1:0] shiftop;
        logic       selimregb;
        logic       selalushift;
        logic       unsig;
        logic [2:0] compop;
        logic [1:0] selbrjumpz;
        logic [1:0] selpctype;
        logic [1:0] selregdest;
        logic       muldiv;
        mem_t       m;
    } ctrl_t;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    ctrl_t  dec;
    logic   dec_ill;
    ctrl_t  ex_q, ex_d;
    mem_t   mem_q, mem_d;
    wb_t    wb_q, wb_d;
    logic   illegal_q, illegal_d;
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic   hold, load_use, accept;

    always_comb begin
        dec     = '0;
        dec_ill = 1'b0;
        case (op)
            6'h00: begin
                dec.m.w.writereg = 1'b1;
                case (fn)
                    6'h20: begin dec.aluop = ALU_ADD; dec.m.w.writeov = 1'b1; end
                    6'h21: begin dec.aluop = ALU_ADD; dec.unsig = 1'b1; end
                    6'h22: begin dec.aluop = ALU_SUB; dec.m.w.writeov = 1'b1; end
                    6'h23: begin dec.aluop = ALU_SUB; dec.unsig = 1'b1; end
                    6'h24: dec.aluop = ALU_AND;
                    6'h25: dec.aluop = ALU_OR;
                    6'h26: dec.aluop = ALU_XOR;
                    6'h27: dec.aluop = ALU_NOR;
                    6'h2a: dec.aluop = ALU_SLT;
                    6'h2b: begin dec.aluop = ALU_SLT; dec.unsig = 1'b1; end
                    6'h00: begin dec.selalushift = 1'b1; dec.shiftop = 2'b00; end
                    6'h02: begin dec.selalushift = 1'b1; dec.shiftop = 2'b01; end
                    6'h03: begin dec.selalushift = 1'b1; dec.shiftop = 2'b10; end
                    6'h08: begin
                        dec.m.w.writereg = 1'b0;
                        dec.selbrjumpz   = 2'b11;
                        dec.selpctype    = 2'b11;
                    end
                    6'h10: begin dec.m.w.selwsource = 3'b010; dec_ill = (HAS_MULDIV == 0); end
                    6'h12: begin dec.m.w.selwsource = 3'b011; dec_ill = (HAS_MULDIV == 0); end
                    6'h18, 6'h19, 6'h1a, 6'h1b: begin
                        dec.m.w.writereg = 1'b0;
                        dec.muldiv       = 1'b1;
                        dec.unsig        = fn[0];
                        dec_ill          = (HAS_MULDIV == 0);
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23: begin
                dec.selimregb    = 1'b1;
                dec.selregdest   = 2'b01;
                dec.m.w.writereg = 1'b1;
                case (op)
                    6'h08: begin dec.aluop = ALU_ADD; dec.m.w.writeov = 1'b1; end
                    6'h09: begin dec.aluop = ALU_ADD; dec.unsig = 1'b1; end
                    6'h0a: dec.aluop = ALU_SLT;
                    6'h0b: begin dec.aluop = ALU_SLT; dec.unsig = 1'b1; end
                    6'h0c: dec.aluop = ALU_AND;
                    6'h0d: dec.aluop = ALU_OR;
                    6'h0e: dec.aluop = ALU_XOR;
                    6'h0f: dec.m.w.selwsource = 3'b100;
                    default: begin
                        dec.aluop          = ALU_ADD;
                        dec.m.readmem      = 1'b1;
                        dec.m.w.selwsource = 3'b001;
                    end
                endcase
            end
            6'h2b: begin dec.aluop = ALU_ADD; dec.selimregb = 1'b1; dec.m.writemem = 1'b1; end
            6'h04: begin dec.selbrjumpz = 2'b01; dec.selpctype = 2'b01; dec.compop = 3'b000; end
            6'h05: begin dec.selbrjumpz = 2'b01; dec.selpctype = 2'b01; dec.compop = 3'b001; end
            6'h02: begin dec.selbrjumpz = 2'b10; dec.selpctype = 2'b10; end
            6'h03: begin
                dec.selbrjumpz     = 2'b10;
                dec.selpctype      = 2'b10;
                dec.selregdest     = 2'b10;
                dec.m.w.writereg   = 1'b1;
                dec.m.w.selwsource = 3'b101;
            end
            default: dec_ill = 1'b1;
        endcase
        case (dec.selregdest)
            2'b01:   dec.m.w.dest = rt;
            2'b10:   dec.m.w.dest = REGW'(31);
            default: dec.m.w.dest = rd;
        endcase
        if (dec_ill) begin
            dec = '0;
        end
    end

    // A held mult/div keeps EX until its last cycle (counter at 0), when EX advances normally.
    assign hold     = (state_q == BUSY) && (cnt_q != 4'd0);
    assign load_use = ex_q.m.readmem && (ex_q.m.w.dest != '0) && id_valid &&
                      ((ex_q.m.w.dest == rs) || (ex_q.m.w.dest == rt));
    assign stall    = !flush && (hold || load_use);
    assign accept   = id_valid && !stall && !flush;

    always_comb begin
        ex_d             = ex_q;
        mem_d            = '0;
        wb_d             = mem_q.w;
        wb_d.writereg    = mem_q.w.writereg && (mem_q.w.dest != '0);
        illegal_d        = 1'b0;
        state_d          = state_q;
        cnt_d            = cnt_q;
        if (hold) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            mem_d     = ex_q.m;
            ex_d      = '0;
            illegal_d = accept && dec_ill;
            if (accept) begin
                ex_d = dec;
            end
            if (ex_d.muldiv && (MULDIV_LAT > 1)) begin
                state_d = BUSY;
                cnt_d   = LAT_M1;
            end else begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            illegal_q <= illegal_d;
        end
    end

    assign illegal        = illegal_q;
    assign ex_aluop       = ex_q.aluop;
    assign ex_shiftop     = ex_q.shiftop;
    assign ex_selimregb   = ex_q.selimregb;
    assign ex_selalushift = ex_q.selalushift;
    assign ex_unsig       = ex_q.unsig;
    assign ex_compop      = ex_q.compop;
    assign ex_selbrjumpz  = ex_q.selbrjumpz;
    assign ex_selpctype   = ex_q.selpctype;
    assign ex_selregdest  = ex_q.selregdest;
    assign ex_muldiv      = ex_q.muldiv;
    assign mem_readmem    = mem_q.readmem;
    assign mem_writemem   = mem_q.writemem;
    assign wb_writereg    = wb_q.writereg;
    assign wb_writeov     = wb_q.writeov;
    assign wb_selwsource  = wb_q.selwsource;
    assign wb_dest        = wb_q.dest;

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: directed literal checks plus randomized traffic compared
// every cycle against an instruction-level model of the control pipeline.
module tb_control_pipe;

    localparam int LAT = 4;

    logic       clock, reset, id_valid, flush;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic       stall, illegal;
    logic [2:0] ex_aluop, ex_compop, wb_selwsource;
    logic [1:0] ex_shiftop, ex_selbrjumpz, ex_selpctype, ex_selregdest;
    logic       ex_selimregb, ex_selalushift, ex_unsig, ex_muldiv;
    logic       mem_readmem, mem_writemem, wb_writereg, wb_writeov;
    logic [4:0] wb_dest;

    control_pipe #(.MULDIV_LAT(LAT), .HAS_MULDIV(1), .REGW(5)) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .op(op), .fn(fn),
        .rs(rs), .rt(rt), .rd(rd), .flush(flush), .stall(stall), .illegal(illegal),
        .ex_aluop(ex_aluop), .ex_shiftop(ex_shiftop), .ex_selimregb(ex_selimregb),
        .ex_selalushift(ex_selalushift), .ex_unsig(ex_unsig), .ex_compop(ex_compop),
        .ex_selbrjumpz(ex_selbrjumpz), .ex_selpctype(ex_selpctype),
        .ex_selregdest(ex_selregdest), .ex_muldiv(ex_muldiv),
        .mem_readmem(mem_readmem), .mem_writemem(mem_writemem),
        .wb_writereg(wb_writereg), .wb_writeov(wb_writeov),
        .wb_selwsource(wb_selwsource), .wb_dest(wb_dest)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef enum int {
        I_ILL, I_ADD, I_ADDU, I_SUB, I_SUBU, I_AND, I_OR, I_XOR, I_NOR, I_SLT, I_SLTU,
        I_SLL, I_SRL, I_SRA, I_JR, I_MFHI, I_MFLO, I_MULT, I_MULTU, I_DIV, I_DIVU,
        I_ADDI, I_ADDIU, I_SLTI, I_SLTIU, I_ANDI, I_ORI, I_XORI, I_LUI, I_LW, I_SW,
        I_BEQ, I_BNE, I_J, I_JAL
    } mn_t;

    typedef struct packed {
        logic [2:0] alu;
        logic [1:0] sh;
        logic       imm, ash, uns;
        logic [2:0] cmp;
        logic [1:0] bj, pc, rdst;
        logic       md, rm, wm, wr, ov;
        logic [2:0] ws;
        logic [4:0] dst;
    } w_t;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic mn_t classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h00: case (f)
                6'h20: return I_ADD;   6'h21: return I_ADDU;  6'h22: return I_SUB;
                6'h23: return I_SUBU;  6'h24: return I_AND;   6'h25: return I_OR;
                6'h26: return I_XOR;   6'h27: return I_NOR;   6'h2a: return I_SLT;
                6'h2b: return I_SLTU;  6'h00: return I_SLL;   6'h02: return I_SRL;
                6'h03: return I_SRA;   6'h08: return I_JR;    6'h10: return I_MFHI;
                6'h12: return I_MFLO;  6'h18: return I_MULT;  6'h19: return I_MULTU;
                6'h1a: return I_DIV;   6'h1b: return I_DIVU;
                default: return I_ILL;
            endcase
            6'h08: return I_ADDI;  6'h09: return I_ADDIU; 6'h0a: return I_SLTI;
            6'h0b: return I_SLTIU; 6'h0c: return I_ANDI;  6'h0d: return I_ORI;
            6'h0e: return I_XORI;  6'h0f: return I_LUI;   6'h23: return I_LW;
            6'h2b: return I_SW;    6'h04: return I_BEQ;   6'h05: return I_BNE;
            6'h02: return I_J;     6'h03: return I_JAL;
            default: return I_ILL;
        endcase
    endfunction

    // Control word described by instruction-class membership.
    function automatic w_t semantics(input mn_t m, input logic [4:0] rt_i, input logic [4:0] rd_i);
        w_t w;
        w = '0;
        if (m inside {I_ADD, I_ADDU, I_ADDI, I_ADDIU, I_LW, I_SW}) w.alu = 3'd1;
        if (m inside {I_SUB, I_SUBU})                       w.alu = 3'd2;
        if (m inside {I_AND, I_ANDI})                       w.alu = 3'd3;
        if (m inside {I_OR, I_ORI})                         w.alu = 3'd4;
        if (m inside {I_XOR, I_XORI})                       w.alu = 3'd5;
        if (m == I_NOR)                                     w.alu = 3'd6;
        if (m inside {I_SLT, I_SLTU, I_SLTI, I_SLTIU})      w.alu = 3'd7;
        w.ash = m inside {I_SLL, I_SRL, I_SRA};
        w.sh  = (m == I_SRL) ? 2'd1 : (m == I_SRA) ? 2'd2 : 2'd0;
        w.imm = m inside {I_ADDI, I_ADDIU, I_SLTI, I_SLTIU, I_ANDI, I_ORI, I_XORI, I_LUI, I_LW, I_SW};
        w.uns = m inside {I_ADDU, I_SUBU, I_SLTU, I_MULTU, I_DIVU, I_ADDIU, I_SLTIU};
        w.ov  = m inside {I_ADD, I_SUB, I_ADDI};
        w.md  = m inside {I_MULT, I_MULTU, I_DIV, I_DIVU};
        w.rm  = (m == I_LW);
        w.wm  = (m == I_SW);
        w.cmp = (m == I_BNE) ? 3'd1 : 3'd0;
        w.bj  = (m inside {I_BEQ, I_BNE}) ? 2'd1 : (m inside {I_J, I_JAL}) ? 2'd2 : (m == I_JR) ? 2'd3 : 2'd0;
        w.pc  = w.bj;
        w.wr  = m inside {I_ADD, I_ADDU, I_SUB, I_SUBU, I_AND, I_OR, I_XOR, I_NOR, I_SLT, I_SLTU,
                          I_SLL, I_SRL, I_SRA, I_MFHI, I_MFLO, I_ADDI, I_ADDIU, I_SLTI, I_SLTIU,
                          I_ANDI, I_ORI, I_XORI, I_LUI, I_LW, I_JAL};
        w.ws  = (m == I_LW) ? 3'd1 : (m == I_MFHI) ? 3'd2 : (m == I_MFLO) ? 3'd3 :
                (m == I_LUI) ? 3'd4 : (m == I_JAL) ? 3'd5 : 3'd0;
        w.rdst = (w.imm && m != I_SW) ? 2'd1 : (m == I_JAL) ? 2'd2 : 2'd0;
        w.dst  = (w.rdst == 2'd1) ? rt_i : (w.rdst == 2'd2) ? 5'd31 : rd_i;
        return w;
    endfunction

    // Model state: one instruction record per stage, EX occupancy in cycles.
    w_t   m_ex, m_mem, m_wb, m_nwb;
    logic m_ill, m_acc;
    int   m_left;
    mn_t  m_mn;
    bit   chk_en = 1'b0;

    function automatic logic m_stall();
        logic lu;
        lu = m_ex.rm && (m_ex.dst != 5'd0) && id_valid && ((m_ex.dst == rs) || (m_ex.dst == rt));
        return !flush && ((m_left > 1) || lu);
    endfunction

    always @(posedge clock) begin
        if (!reset) begin
            m_ex = '0; m_mem = '0; m_wb = '0; m_ill = 1'b0; m_left = 0;
            chk_en = 1'b1;
        end else begin
            m_acc = id_valid && !m_stall() && !flush;
            m_nwb = m_mem;
            if (m_nwb.dst == 5'd0) m_nwb.wr = 1'b0;
            if (m_left > 1) begin
                m_mem = '0;
                m_left--;
                m_ill = 1'b0;
            end else begin
                m_mem = m_ex;
                m_mn  = classify(op, fn);
                m_ex  = (m_acc && m_mn != I_ILL) ? semantics(m_mn, rt, rd) : '0;
                m_ill = m_acc && (m_mn == I_ILL);
                m_left = m_ex.md ? LAT : 0;
            end
            m_wb = m_nwb;
        end
    end

    always @(negedge clock) begin
        #2;
        if (chk_en) begin
            chk("stall", 32'(stall), 32'(m_stall()));
            chk("illegal", 32'(illegal), 32'(m_ill));
            chk("ex_word", 32'({ex_aluop, ex_shiftop, ex_selimregb, ex_selalushift, ex_unsig,
                                ex_compop, ex_selbrjumpz, ex_selpctype, ex_selregdest, ex_muldiv}),
                32'({m_ex.alu, m_ex.sh, m_ex.imm, m_ex.ash, m_ex.uns, m_ex.cmp, m_ex.bj,
                     m_ex.pc, m_ex.rdst, m_ex.md}));
            chk("mem_word", 32'({mem_readmem, mem_writemem}), 32'({m_mem.rm, m_mem.wm}));
            chk("wb_word", 32'({wb_writereg, wb_writeov, wb_selwsource, wb_dest}),
                32'({m_wb.wr, m_wb.ov, m_wb.ws, m_wb.dst}));
        end
    end

    task automatic put(input logic v, input logic [5:0] o, input logic [5:0] f,
                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                       input logic fl);
        id_valid = v; op = o; fn = f; rs = s; rt = t; rd = d; flush = fl;
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        put(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    logic [5:0] ops [19];
    logic [5:0] fns [20];
    int stall_n, md_n, add_at;

    initial begin
        ops = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d,
                6'h0e, 6'h0f, 6'h23, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03};
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
                6'h00, 6'h02, 6'h03, 6'h08, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1a, 6'h1b};

        // Reset held two edges with a lw waiting in ID.
        reset = 1'b0;
        put(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 1'b0);
        tick();
        tick();
        chk("rst_ex_aluop", 32'(ex_aluop), 32'd0);
        chk("rst_mem_readmem", 32'(mem_readmem), 32'd0);
        chk("rst_wb_writereg", 32'(wb_writereg), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        reset = 1'b1;
        #1 chk("rst_release_stall", 32'(stall), 32'd0);
        tick();

        // add $3,$1,$2 behind the lw.
        put(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 1'b0);
        #1 chk("add_no_stall", 32'(stall), 32'd0);
        tick();
        chk("add_ex_aluop", 32'(ex_aluop), 32'd1);
        chk("lw_mem_readmem", 32'(mem_readmem), 32'd1);
        idle();
        tick();
        tick();
        chk("add_wb_writereg", 32'(wb_writereg), 32'd1);
        chk("add_wb_dest", 32'(wb_dest), 32'd3);
        chk("add_wb_writeov", 32'(wb_writeov), 32'd1);

        // Load-use: lw $5 then add $6,$5,$1.
        put(1'b1, 6'h23, 6'h00, 5'd0, 5'd5, 5'd0, 1'b0);
        tick();
        put(1'b1, 6'h00, 6'h20, 5'd5, 5'd1, 5'd6, 1'b0);
        #1 chk("lu_stall", 32'(stall), 32'd1);
        tick();
        #1 chk("lu_stall_one_cycle", 32'(stall), 32'd0);
        chk("lu_ex_bubble", 32'(ex_aluop), 32'd0);
        tick();
        idle();
        tick();
        tick();
        chk("lu_add_wb_dest", 32'(wb_dest), 32'd6);
        chk("lu_add_wb_writereg", 32'(wb_writereg), 32'd1);

        // mult followed by an add waiting in ID.
        put(1'b1, 6'h00, 6'h18, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        put(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd7, 1'b0);
        stall_n = 0; md_n = 0; add_at = -1;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (stall) stall_n++;
            if (ex_muldiv) md_n++;
            if (add_at < 0 && ex_aluop == 3'd1) add_at = k;
            tick();
        end
        chk("mul_stall_cycles", 32'(stall_n), 32'd3);
        chk("mul_ex_cycles", 32'(md_n), 32'd4);
        chk("mul_add_enters_ex", 32'(add_at), 32'd4);
        idle();
        tick();
        tick();

        // Flush kills a sw in ID.
        put(1'b1, 6'h2b, 6'h00, 5'd1, 5'd2, 5'd0, 1'b1);
        tick();
        chk("flush_ex_bubble", 32'(ex_selimregb), 32'd0);
        idle();
        tick();
        chk("flush_mem_writemem", 32'(mem_writemem), 32'd0);

        // Flush overrides a load-use stall.
        put(1'b1, 6'h23, 6'h00, 5'd0, 5'd5, 5'd0, 1'b0);
        tick();
        put(1'b1, 6'h00, 6'h20, 5'd5, 5'd1, 5'd6, 1'b1);
        #1 chk("flush_lu_stall", 32'(stall), 32'd0);
        tick();
        chk("flush_lu_ex_bubble", 32'(ex_aluop), 32'd0);
        idle();
        tick();

        // Illegal opcode.
        put(1'b1, 6'h3f, 6'h00, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_ex_word", 32'({ex_aluop, ex_selimregb, ex_selbrjumpz, ex_muldiv, ex_selregdest}), 32'd0);
        idle();
        tick();
        chk("ill_one_cycle", 32'(illegal), 32'd0);

        // addi to $0 never writes.
        put(1'b1, 6'h08, 6'h00, 5'd1, 5'd0, 5'd9, 1'b0);
        tick();
        idle();
        tick();
        tick();
        chk("r0_wb_writereg", 32'(wb_writereg), 32'd0);
        chk("r0_wb_writeov", 32'(wb_writeov), 32'd1);

        // Reset in the middle of a mult.
        put(1'b1, 6'h00, 6'h1a, 5'd1, 5'd2, 5'd0, 1'b0);
        tick();
        idle();
        #1 chk("busy_stall", 32'(stall), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1 chk("busy_rst_stall", 32'(stall), 32'd0);
        chk("busy_rst_muldiv", 32'(ex_muldiv), 32'd0);
        tick();

        // Randomized traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 299) != 0);
            id_valid = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 99) < 8) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end else begin
                op = ops[$urandom_range(0, 18)];
                fn = fns[$urandom_range(0, 19)];
            end
            rs    = 5'($urandom_range(0, 7));
            rt    = 5'($urandom_range(0, 7));
            rd    = 5'($urandom_range(0, 7));
            flush = ($urandom_range(0, 15) == 0);
            tick();
        end
        reset = 1'b1;
        idle();
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/control_pipe.md
# control_pipe

Pipelined control unit for the MIPS core. Decodes the ID-stage `op`/`fn` into a control word, then carries it through registered EX, MEM and WB stages. It detects load-use hazards, sequences multi-cycle mult/div, and applies flushes. It replaces the purely combinational decoder, and the datapath pipeline registers consume its stage-aligned outputs.

## Interface
- `MULDIV_LAT`, 4: cycles EX is occupied by mult/div (1..15).
- `HAS_MULDIV`, 1: 0 makes mult/div decode as illegal.
- `REGW`, 5: register index width.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low; sampled on `clock` rising edge.
- `id_valid` in 1: ID holds a real instruction.
- `op` in 6, `fn` in 6: instruction fields [31:26], [5:0].
- `rs`, `rt`, `rd` in REGW: source and destination indices.
- `flush` in 1: branch/jump taken in EX; kill ID instruction.
- `stall` out 1: hold PC and IF/ID register.
- `illegal` out 1: ID instruction undecodable; registered with EX.
- `ex_aluop` out 3, `ex_shiftop` out 2, `ex_selimregb` out 1, `ex_selalushift` out 1, `ex_unsig` out 1, `ex_compop` out 3, `ex_selbrjumpz` out 2, `ex_selpctype` out 2, `ex_selregdest` out 2: EX-stage controls.
- `ex_muldiv` out 1: a mult/div is in EX.
- `mem_readmem` out 1, `mem_writemem` out 1: MEM-stage controls.
- `wb_writereg` out 1, `wb_writeov` out 1, `wb_selwsource` out 3, `wb_dest` out REGW: WB-stage controls and resolved destination.

## Operation
- **Decode is combinational in ID.** The word is registered into EX when `id_valid & !stall & !flush`; otherwise a bubble (all-zero word) enters EX.
- **Destination.** Resolved at decode from `selregdest`:
  - 00 → `rd` (R-type)
  - 01 → `rt` (I-type)
  - 10 → 31 (jal)
- **Decode classes:**
  - R-ALU: `aluop` from `fn`.
  - Shifts: `selalushift`=1, `shiftop` 00 sll, 01 srl, 10 sra.
  - I-ALU: `selimregb`=1.
  - lw: `readmem`, `selwsource`=001.
  - sw: `writemem`, `writereg`=0.
  - beq/bne: `selbrjumpz`=01, `compop` 000/001.
  - j/jal: `selbrjumpz`=10.
  - jr: `selbrjumpz`=11.
  - Unsigned variants set `unsig`.
  - add/addi/sub set `writeov`.
- **Illegal encodings** produce a bubble word with `illegal`=1 in EX.
- **Writes to register 0.** `wb_writereg` is forced 0 whenever `wb_dest`=0.
- **Stage advance.** EX→MEM→WB advance every cycle, except while mult/div holds EX (see below).
- **Load-use hazard.** Asserted when `ex` readmem & `ex_dest`≠0 & (`ex_dest`==`rs` | `ex_dest`==`rt`) & `id_valid`. Response:
  - `stall`=1 for exactly one cycle.
  - A bubble enters EX.
- **Mult/div FSM:** states IDLE, BUSY.
  - IDLE→BUSY when a mult/div word enters EX; counter loads `MULDIV_LAT`-1.
  - BUSY: EX word held, `stall`=1, a bubble enters MEM each cycle, counter decrements.
  - BUSY→IDLE at counter=0; EX then advances normally on the next edge.
  - `MULDIV_LAT`=1: never enters BUSY.
- **Priority:** `flush` > BUSY > load-use.
  - `flush` during BUSY kills only the ID instruction; the mult/div completes.
  - `flush` also suppresses a load-use stall in the same cycle.

## Timing
- **Reset.** While `reset`=0 on an edge, all stage registers are cleared to the bubble:
  - `stall`=0, `illegal`=0, FSM=IDLE, counter=0.
  - All `ex_*`/`mem_*`/`wb_*` outputs are 0.
- **Mid-operation reset.** Reset asserted during BUSY returns to IDLE in one edge.
- **Latency.** ID to EX is 1 cycle, to MEM 2, to WB 3; each stall cycle adds 1.
- `stall` is combinational from ID inputs and registered state; no other output is combinational.
- **Back-to-back mult/div.** The second one stalls in ID until the first leaves EX, then enters EX with no gap cycle.

## Test plan
- **Reset:** hold `reset`=0 two cycles with `id_valid`=1 and op=lw → all outputs 0, and `stall`=0 on the release cycle.
- **Plain flow:** add $3,$1,$2 (op 000000, fn 100000, rd=3) → EX `aluop` add next cycle, `wb_writereg`=1, `wb_dest`=3, `wb_writeov`=1 three cycles after issue.
- **Load-use:** lw $5 then add $6,$5,$1 → `stall`=1 for one cycle, bubble in EX, add reaches WB 4 cycles after issue.
- **Mult/div:** mult, `MULDIV_LAT`=4 → `stall`=1 for 3 cycles, `ex_muldiv`=1 for 4 cycles, three bubbles reach MEM.
- **Flush:** `flush`=1 with sw in ID → `mem_writemem` stays 0; flush+load-use in the same cycle → `stall`=0.
- **Edge cases:** op=111111 → `illegal`=1 for one cycle, all other controls 0. addi to $0 → `wb_writereg`=0. Reset asserted during BUSY → IDLE and `stall`=0 next cycle.
